// File: rtl/wsmac_pe.sv
// rtl/wsmac_pe.sv - weight-stationary signed MAC processing element, two-stage pipeline
module wsmac_pe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter bit SAT_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              w_wr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              w_swap,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] feature_in,
    input  logic [ACC_W-1:0]  accum_in,
    input  logic              mode,
    input  logic              clr,
    input  logic              ovf_clr,
    output logic [DATA_W-1:0] feature_out,
    output logic              valid_out,
    output logic [ACC_W-1:0]  accum_out,
    output logic              ovf_sticky
);

    generate
        if (ACC_W < 2 * DATA_W + 1) begin : g_acc_w_check
            $error("wsmac_pe: ACC_W must be at least 2*DATA_W+1");
        end
    endgenerate

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [DATA_W-1:0]   w_shadow;
    logic [DATA_W-1:0]   w_active;
    logic                s1_valid;
    logic                s1_mode;
    logic                s1_clr;
    logic [DATA_W-1:0]   s1_feature;
    logic [DATA_W-1:0]   s1_weight;
    logic [ACC_W-1:0]    s1_accum;
    logic [ACC_W-1:0]    acc_held;

    logic [2*DATA_W-1:0] w_ext;
    logic [2*DATA_W-1:0] f_ext;
    logic [2*DATA_W-1:0] product;
    logic [ACC_W-1:0]    base;
    logic [ACC_W:0]      sum;
    logic                ovf;
    logic [ACC_W-1:0]    result;

    // A simultaneous write and swap bypasses the shadow so the new weight is live at once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_shadow <= '0;
            w_active <= '0;
        end else begin
            if (w_wr) begin
                w_shadow <= w_data;
            end
            if (w_swap) begin
                w_active <= w_wr ? w_data : w_shadow;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_mode    <= 1'b0;
            s1_clr     <= 1'b0;
            s1_feature <= '0;
            s1_weight  <= '0;
            s1_accum   <= '0;
        end else begin
            s1_valid <= valid_in;
            if (valid_in) begin
                s1_mode    <= mode;
                s1_clr     <= clr;
                s1_feature <= feature_in;
                s1_weight  <= w_active;
                s1_accum   <= accum_in;
            end
        end
    end

    // Low 2*DATA_W bits of the product of sign-extended operands equal the signed product.
    assign w_ext   = {{DATA_W{s1_weight[DATA_W-1]}}, s1_weight};
    assign f_ext   = {{DATA_W{s1_feature[DATA_W-1]}}, s1_feature};
    assign product = w_ext * f_ext;

    always_comb begin
        base = s1_accum;
        if (s1_mode) begin
            base = s1_clr ? '0 : acc_held;
        end
    end

    assign sum = {base[ACC_W-1], base}
               + {{(ACC_W + 1 - 2 * DATA_W){product[2*DATA_W-1]}}, product};
    assign ovf = sum[ACC_W] ^ sum[ACC_W-1];

    always_comb begin
        result = sum[ACC_W-1:0];
        if (SAT_EN && ovf) begin
            result = sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_out   <= 1'b0;
            acc_held    <= '0;
            accum_out   <= '0;
            feature_out <= '0;
            ovf_sticky  <= 1'b0;
        end else begin
            valid_out <= s1_valid;
            if (s1_valid) begin
                acc_held    <= result;
                accum_out   <= result;
                feature_out <= s1_feature;
            end
            // A new overflow wins over a clear in the same cycle.
            if (s1_valid && ovf) begin
                ovf_sticky <= 1'b1;
            end else if (ovf_clr) begin
                ovf_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wsmac_pe.sv
// tb/tb_wsmac_pe.sv - directed and random checks of wsmac_pe against an arithmetic model
module tb_wsmac_pe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        w_wr;
    logic [7:0]  w_data;
    logic        w_swap;
    logic        valid_in;
    logic [7:0]  feature_in;
    logic [31:0] accum_in;
    logic        mode;
    logic        clr;
    logic        ovf_clr;

    logic [7:0]  s_feature_out, w_feature_out;
    logic        s_valid_out, w_valid_out;
    logic [31:0] s_accum_out, w_accum_out;
    logic        s_ovf_sticky, w_ovf_sticky;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0]  m_shadow, m_active;
    bit          p_v;
    logic [7:0]  p_w, p_f;
    logic [31:0] p_a;
    bit          p_mode, p_clr;
    logic [31:0] m_held_s, m_held_w;
    bit          e_vout;
    logic [7:0]  e_fout;
    logic [31:0] e_acc_s, e_acc_w;
    bit          e_ovf_s, e_ovf_w;

    always #5 clk = ~clk;

    wsmac_pe #(.DATA_W(8), .ACC_W(32), .SAT_EN(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .w_wr(w_wr), .w_data(w_data), .w_swap(w_swap),
        .valid_in(valid_in), .feature_in(feature_in), .accum_in(accum_in),
        .mode(mode), .clr(clr), .ovf_clr(ovf_clr),
        .feature_out(s_feature_out), .valid_out(s_valid_out),
        .accum_out(s_accum_out), .ovf_sticky(s_ovf_sticky)
    );

    wsmac_pe #(.DATA_W(8), .ACC_W(32), .SAT_EN(1'b0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .w_wr(w_wr), .w_data(w_data), .w_swap(w_swap),
        .valid_in(valid_in), .feature_in(feature_in), .accum_in(accum_in),
        .mode(mode), .clr(clr), .ovf_clr(ovf_clr),
        .feature_out(w_feature_out), .valid_out(w_valid_out),
        .accum_out(w_accum_out), .ovf_sticky(w_ovf_sticky)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    // Signed arithmetic on wide integers, then range reduction.
    function automatic void calc(input longint base, input longint prod, input bit sat,
                                 output logic [31:0] res, output bit ovf);
        longint s;
        s   = base + prod;
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        if (ovf && sat) res = (s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        else            res = s[31:0];
    endfunction

    task automatic model_update();
        longint      prod, base_s, base_w;
        logic [31:0] r_s, r_w;
        bit          o_s, o_w;
        logic [7:0]  new_active;
        if (!rst_n) begin
            m_shadow = '0; m_active = '0; p_v = 0; p_w = '0; p_f = '0; p_a = '0;
            p_mode = 0; p_clr = 0; m_held_s = '0; m_held_w = '0;
            e_vout = 0; e_fout = '0; e_acc_s = '0; e_acc_w = '0; e_ovf_s = 0; e_ovf_w = 0;
            return;
        end
        e_vout = p_v;
        o_s = 0; o_w = 0;
        if (p_v) begin
            prod = longint'($signed(p_w)) * longint'($signed(p_f));
            if (!p_mode) begin
                base_s = longint'($signed(p_a)); base_w = base_s;
            end else if (p_clr) begin
                base_s = 0; base_w = 0;
            end else begin
                base_s = longint'($signed(m_held_s)); base_w = longint'($signed(m_held_w));
            end
            calc(base_s, prod, 1'b1, r_s, o_s);
            calc(base_w, prod, 1'b0, r_w, o_w);
            m_held_s = r_s; m_held_w = r_w; e_acc_s = r_s; e_acc_w = r_w; e_fout = p_f;
        end
        if (o_s) e_ovf_s = 1; else if (ovf_clr) e_ovf_s = 0;
        if (o_w) e_ovf_w = 1; else if (ovf_clr) e_ovf_w = 0;
        p_v = valid_in;
        if (valid_in) begin
            p_w = m_active; p_f = feature_in; p_a = accum_in; p_mode = mode; p_clr = clr;
        end
        new_active = w_wr ? w_data : m_shadow;
        if (w_wr)   m_shadow = w_data;
        if (w_swap) m_active = new_active;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        check("valid_out_sat",   {31'd0, s_valid_out},  {31'd0, e_vout});
        check("valid_out_wrap",  {31'd0, w_valid_out},  {31'd0, e_vout});
        check("feature_out_sat", {24'd0, s_feature_out}, {24'd0, e_fout});
        check("feature_out_wrap",{24'd0, w_feature_out}, {24'd0, e_fout});
        check("accum_out_sat",   s_accum_out, e_acc_s);
        check("accum_out_wrap",  w_accum_out, e_acc_w);
        check("ovf_sticky_sat",  {31'd0, s_ovf_sticky}, {31'd0, e_ovf_s});
        check("ovf_sticky_wrap", {31'd0, w_ovf_sticky}, {31'd0, e_ovf_w});
    endtask

    task automatic idle();
        w_wr = 0; w_swap = 0; valid_in = 0; ovf_clr = 0; mode = 0; clr = 0;
        feature_in = '0; accum_in = '0; w_data = '0;
    endtask

    task automatic load_w(input logic [7:0] w);
        idle(); w_wr = 1; w_swap = 1; w_data = w; tick(); idle();
    endtask

    task automatic sample(input logic [7:0] f, input logic [31:0] a, input bit md, input bit c);
        valid_in = 1; feature_in = f; accum_in = a; mode = md; clr = c;
    endtask

    initial begin
        rst_n = 0; idle();
        tick(); tick();
        check("reset_accum", s_accum_out, 32'd0);
        rst_n = 1;

        // Systolic: 3 * -4 + 100
        load_w(8'd3);
        sample(8'hFC, 32'd100, 0, 0); tick(); idle(); tick();
        check("sys_valid", {31'd0, s_valid_out}, 32'd1);
        check("sys_accum", s_accum_out, 32'd88);
        check("sys_feature", {24'd0, s_feature_out}, 32'h0000_00FC);

        // Local accumulate: 5, 15, 30
        load_w(8'd5);
        sample(8'd1, 32'd0, 1, 1); tick();
        sample(8'd2, 32'd0, 1, 0); tick();
        check("local_1", s_accum_out, 32'd5);
        sample(8'd3, 32'd0, 1, 0); tick();
        check("local_2", s_accum_out, 32'd15);
        idle(); tick();
        check("local_3", s_accum_out, 32'd30);

        // Saturation versus wrap
        load_w(8'd127);
        sample(8'd127, 32'h7FFF_FFF0, 0, 0); tick(); idle(); tick();
        check("sat_value", s_accum_out, 32'h7FFF_FFFF);
        check("wrap_value", w_accum_out, 32'h8000_3EF1);
        check("sat_ovf", {31'd0, s_ovf_sticky}, 32'd1);
        check("wrap_ovf", {31'd0, w_ovf_sticky}, 32'd1);
        ovf_clr = 1; tick(); idle();
        check("ovf_cleared", {31'd0, s_ovf_sticky}, 32'd0);

        // Most negative operands, then clear colliding with a new overflow
        load_w(8'h80);
        sample(8'h80, 32'd0, 0, 0); tick(); idle(); tick();
        check("corner_accum", s_accum_out, 32'd16384);
        check("corner_ovf", {31'd0, s_ovf_sticky}, 32'd0);
        load_w(8'd127);
        sample(8'd127, 32'h7FFF_FFF0, 0, 0); tick(); idle(); ovf_clr = 1; tick();
        check("set_beats_clr", {31'd0, s_ovf_sticky}, 32'd1);
        tick(); idle();
        check("clr_after", {31'd0, s_ovf_sticky}, 32'd0);

        // Swap in the same cycle as a sample
        load_w(8'd2);
        w_wr = 1; w_data = 8'd7; tick(); idle();
        w_swap = 1; sample(8'd10, 32'd0, 0, 0); tick();
        w_swap = 0; sample(8'd10, 32'd0, 0, 0); tick();
        check("swap_old_w", s_accum_out, 32'd20);
        idle(); tick();
        check("swap_new_w", s_accum_out, 32'd70);

        // Mode 1 without clr right after reset accumulates onto zero
        rst_n = 0; tick(); rst_n = 1;
        load_w(8'd4);
        sample(8'd3, 32'd0, 1, 0); tick(); idle(); tick();
        check("first_acc_zero", s_accum_out, 32'd12);

        // Reset with a sample in flight discards it
        sample(8'd9, 32'd55, 0, 0); tick();
        rst_n = 0; tick(); rst_n = 1; idle();
        tick();
        check("rst_flight_v1", {31'd0, s_valid_out}, 32'd0);
        tick();
        check("rst_flight_v2", {31'd0, s_valid_out}, 32'd0);
        check("rst_flight_acc", s_accum_out, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst_n      = ($urandom_range(0, 49) != 0);
            w_wr       = ($urandom_range(0, 3) == 0);
            w_swap     = ($urandom_range(0, 4) == 0);
            w_data     = 8'($urandom);
            valid_in   = ($urandom_range(0, 3) != 0);
            feature_in = 8'($urandom);
            case ($urandom_range(0, 3))
                0: accum_in = 32'h7FFF_C000 + 32'($urandom_range(0, 32767));
                1: accum_in = 32'h8000_0000 + 32'($urandom_range(0, 32767));
                default: accum_in = $urandom;
            endcase
            mode    = $urandom_range(0, 1);
            clr     = ($urandom_range(0, 5) == 0);
            ovf_clr = ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wsmac_pe.md
WSMAC_PE -- requirements
Module: wsmac_pe

Interface
REQ-001 Parameter DATA_W, default 8, signed weight and feature width.
REQ-002 Parameter ACC_W, default 32, signed accumulator width; ACC_W >= 2*DATA_W+1 SHALL be enforced by an elaboration-time check.
REQ-003 Parameter SAT_EN, default 1; 1 = saturate on overflow, 0 = two's-complement wrap.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 w_wr  input  1  write w_data into the shadow weight register.
REQ-007 w_data  input  DATA_W  signed weight to load.
REQ-008 w_swap  input  1  commit shadow weight to the active weight register.
REQ-009 valid_in  input  1  qualifies feature_in, accum_in, mode, clr.
REQ-010 feature_in  input  DATA_W  signed feature stream.
REQ-011 accum_in  input  ACC_W  signed partial sum from the upstream PE.
REQ-012 mode  input  1  0 = systolic (P = accum_in + W*F); 1 = local accumulate (P = P + W*F).
REQ-013 clr  input  1  mode 1 only: use 0 instead of the held accumulator for this sample.
REQ-014 ovf_clr  input  1  clear the sticky overflow flag.
REQ-015 feature_out  output  DATA_W  feature forwarded to the next PE, delay-matched.
REQ-016 valid_out  output  1  qualifies feature_out and accum_out.
REQ-017 accum_out  output  ACC_W  result P.
REQ-018 ovf_sticky  output  1  set when any result overflowed ACC_W.

Function
REQ-019 All arithmetic SHALL be signed two's complement; the product is 2*DATA_W bits; the sum is computed at ACC_W+1 bits before range reduction.
REQ-020 w_wr=1 SHALL load w_data into the shadow register; w_swap=1 SHALL copy the shadow register to the active register.
REQ-021 w_wr and w_swap asserted in the same cycle SHALL load w_data into both the shadow and active registers.
REQ-022 Stage 1: valid_in=1 SHALL register feature_in, accum_in, mode, clr and the active weight value held before that edge. s1_valid SHALL be set to valid_in.
REQ-023 A sample accepted in the same cycle as w_swap SHALL therefore use the old weight; the next sample SHALL use the new weight.
REQ-024 Stage 2: s1_valid=1 SHALL compute base + W*F, where base is accum_in (mode 0), 0 (mode 1, clr=1), or the held accumulator (mode 1, clr=0).
REQ-025 Stage 2 SHALL register the reduced result into the held accumulator and accum_out, set valid_out=1, and register feature_out from the stage-1 feature.
REQ-026 Latency SHALL be exactly 2 cycles from valid_in to valid_out; the PE SHALL accept one sample per cycle with no backpressure.
REQ-027 With s1_valid=0, valid_out SHALL be 0, and accum_out, feature_out and the held accumulator SHALL hold their values.
REQ-028 Overflow means the ACC_W+1-bit sum lies outside the ACC_W signed range.
REQ-029 On overflow with SAT_EN=1, the result SHALL clamp to the maximum positive or maximum negative ACC_W value; with SAT_EN=0 it SHALL keep the low ACC_W bits.
REQ-030 Overflow on a valid stage-2 sample SHALL set ovf_sticky.
REQ-031 ovf_clr SHALL clear ovf_sticky; a set and a clear in the same cycle SHALL leave ovf_sticky=1.
REQ-032 mode 1 with clr=0 on the first sample after reset SHALL accumulate onto 0.

Reset
REQ-033 rst_n=0 at a clock edge SHALL zero the shadow weight, active weight, all stage registers, the held accumulator, s1_valid, valid_out, feature_out, accum_out and ovf_sticky.
REQ-034 Reset SHALL take priority over every other input; in-flight samples SHALL be discarded and SHALL never produce valid_out.

Verification
REQ-035 Systolic: w_wr+w_swap with 3; valid_in, F=-4, accum_in=100, mode=0 -> 2 cycles later valid_out=1, accum_out=88, feature_out=0xFC.
REQ-036 Local accumulate: W=5, F=1,2,3 on consecutive cycles, mode=1, clr=1 on the first sample -> accum_out 5, 15, 30 on 3 consecutive cycles.
REQ-037 Saturation: W=127, F=127, accum_in=0x7FFFFFF0 -> SAT_EN=1 gives 0x7FFFFFFF and ovf_sticky=1; SAT_EN=0 gives 0x80003EF1 and ovf_sticky=1.
REQ-038 Swap timing: active W=2, shadow W=7; w_swap in the same cycle as F=10 (accum_in=0), then F=10 again -> accum_out 20 then 70.
REQ-039 Corner: W=-128, F=-128, accum_in=0 -> accum_out=16384, ovf_sticky=0. ovf_clr together with an overflowing sample -> ovf_sticky stays 1.
REQ-040 Reset mid-operation: rst_n=0 for one cycle while s1_valid=1 -> valid_out=0 on the following two cycles and all outputs 0.
